cam_pixpack: RTL and testbench

- Upstream neighbour of the capture VRAM write controller.
- Accepts a 24-bit RGB camera pixel stream in the ACLK domain and packs two pixels into one 48-bit word.
- Buffers packed words in an internal FIFO and exposes the FIFORD/FIFOVALID/FIFODATA read side plus HASDATA and START_SCREEN that the write controller consumes.
- Also handles frame alignment and overflow reporting.

---
 rtl/cam_pixpack.sv | 177 +++++++++++++++++
 tb/tb_cam_pixpack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixpack.sv
// -----------------------------------------------------------------------------
// cam_pixpack
//
// Packs a 24-bit RGB camera pixel stream into 48-bit pixel pairs and buffers
// them in a FIFO. The capture VRAM write controller drains the FIFO through
// the FIFORD/FIFOVALID/FIFODATA read side and uses HASDATA and START_SCREEN.
// This block also aligns the FIFO to frame starts and reports overflow.
//
// Parameters
//   DEPTH_LOG2  log2 of FIFO depth in 48-bit words (default 6 -> 64 words)
//   BURST_LEN   words that must be stored before HASDATA asserts
//               (must be <= 2**DEPTH_LOG2)
//
// Optional build macro
//   CAM_PIXPACK_BGR_SWAP_EN  when defined, each incoming pixel is reordered
//                            from {R,G,B} to {B,G,R} before packing.
//
// Ports
//   ACLK          clock
//   ARSTN         asynchronous active-low reset
//   CAP_EN        capture enable; pixels are ignored while low
//   PIX_VALID     pixel qualifier
//   PIX_DATA      pixel {R,G,B}, R in [23:16]
//   PIX_SOF       first pixel of a frame (qualified by CAP_EN & PIX_VALID)
//   FIFORD        read request from the write controller
//   FIFOVALID     read data valid, one cycle after an accepted FIFORD
//   FIFODATA      packed pair {later pixel, earlier pixel}; holds until next pop
//   HASDATA       registered (WORD_COUNT >= BURST_LEN)
//   START_SCREEN  one-cycle pulse the cycle after a start-of-frame pixel
//   OVERFLOW      sticky: a packed word was dropped on a full FIFO
//   WORD_COUNT    words currently stored
// -----------------------------------------------------------------------------
module cam_pixpack #(
  parameter int DEPTH_LOG2 = 6,
  parameter int BURST_LEN  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARSTN,
  input  logic                  CAP_EN,
  input  logic                  PIX_VALID,
  input  logic [23:0]           PIX_DATA,
  input  logic                  PIX_SOF,
  input  logic                  FIFORD,
  output logic                  FIFOVALID,
  output logic [47:0]           FIFODATA,
  output logic                  HASDATA,
  output logic                  START_SCREEN,
  output logic                  OVERFLOW,
  output logic [DEPTH_LOG2:0]   WORD_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   BURST_COUNT = (DEPTH_LOG2 + 1)'(BURST_LEN);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

  // ---------------------------------------------------------------------------
  // Pixel conditioning
  // ---------------------------------------------------------------------------
  logic [23:0] pix_in;

`ifdef CAM_PIXPACK_BGR_SWAP_EN
  assign pix_in = {PIX_DATA[7:0], PIX_DATA[15:8], PIX_DATA[23:16]};
`else
  assign pix_in = PIX_DATA;
`endif

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic                  phase;     // 1: holding register has the low half
  logic [23:0]           hold;      // earlier pixel of the pair in progress
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic accept;
  logic sof;
  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign accept = CAP_EN & PIX_VALID;
  assign sof    = accept & PIX_SOF;

  // A start-of-frame pixel always opens a new pair, so it never completes
  // the old one; reads in that cycle are ignored because the FIFO is flushed.
  assign push   = accept & phase & ~sof;
  assign pop    = FIFORD & (WORD_COUNT != '0) & ~sof;
  assign full   = (WORD_COUNT == FULL_COUNT);

  // A simultaneous pop frees the slot, so a push into a full FIFO still
  // succeeds in that cycle.
  assign push_ok = push & (~full | pop);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [47:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM primitives;
  // every location is written before the read pointer can reach it.
  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= {pix_in, hold};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, pair assembly and status outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      WORD_COUNT   <= '0;
      phase        <= 1'b0;
      hold         <= '0;
      FIFOVALID    <= 1'b0;
      FIFODATA     <= '0;
      HASDATA      <= 1'b0;
      START_SCREEN <= 1'b0;
      OVERFLOW     <= 1'b0;
    end else begin
      START_SCREEN <= sof;
      HASDATA      <= (WORD_COUNT >= BURST_COUNT);
      FIFOVALID    <= pop;

      if (pop) begin
        FIFODATA <= mem[rd_ptr];
      end

      if (sof) begin
        // Frame realignment: flush the FIFO, drop any half pair and start
        // the new frame with the SOF pixel as the low half.
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        WORD_COUNT <= '0;
        OVERFLOW   <= 1'b0;
        hold       <= pix_in;
        phase      <= 1'b1;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push && !push_ok) begin
          OVERFLOW <= 1'b1;
        end

        unique case ({push_ok, pop})
          2'b10:   WORD_COUNT <= WORD_COUNT + COUNT_ONE;
          2'b01:   WORD_COUNT <= WORD_COUNT - COUNT_ONE;
          default: WORD_COUNT <= WORD_COUNT;
        endcase

        // The holding register is only touched by accepted pixels, so a
        // half pair survives CAP_EN dropping mid-pair.
        if (accept) begin
          if (phase) begin
            phase <= 1'b0;
          end else begin
            hold  <= pix_in;
            phase <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixpack.sv
// -----------------------------------------------------------------------------
// tb_cam_pixpack
//
// Self-checking bench for cam_pixpack. A queue-based model tracks what the
// FIFO must hold and what every output must show; a compare process checks
// the DUT against it on each falling clock edge. Directed sequences pin the
// model with literal expectations, then randomized traffic exercises it.
// -----------------------------------------------------------------------------
module tb_cam_pixpack;

  localparam int DEPTH_LOG2 = 6;
  localparam int BURST_LEN  = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

`ifdef CAM_PIXPACK_BGR_SWAP_EN
  localparam logic [47:0] W0 = 48'h665544332211;
  localparam logic [47:0] W1 = 48'hCCBBAA998877;
  localparam logic [47:0] W3 = 48'h00FF00FF0000;
`else
  localparam logic [47:0] W0 = 48'h445566112233;
  localparam logic [47:0] W1 = 48'hAABBCC778899;
  localparam logic [47:0] W3 = 48'h00FF000000FF;
`endif

  logic                clk = 1'b0;
  logic                arstn = 1'b1;
  logic                cap_en = 1'b0;
  logic                pix_valid = 1'b0;
  logic [23:0]         pix_data = '0;
  logic                pix_sof = 1'b0;
  logic                fiford = 1'b0;
  logic                fifovalid;
  logic [47:0]         fifodata;
  logic                hasdata;
  logic                start_screen;
  logic                overflow;
  logic [DEPTH_LOG2:0] word_count;

  int checks   = 0;
  int failures = 0;

  cam_pixpack #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .ACLK         (clk),
    .ARSTN        (arstn),
    .CAP_EN       (cap_en),
    .PIX_VALID    (pix_valid),
    .PIX_DATA     (pix_data),
    .PIX_SOF      (pix_sof),
    .FIFORD       (fiford),
    .FIFOVALID    (fifovalid),
    .FIFODATA     (fifodata),
    .HASDATA      (hasdata),
    .START_SCREEN (start_screen),
    .OVERFLOW     (overflow),
    .WORD_COUNT   (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] sw(input logic [23:0] p);
`ifdef CAM_PIXPACK_BGR_SWAP_EN
    return {p[7:0], p[15:8], p[23:16]};
`else
    return p;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of stored words plus the expected outputs.
  // ---------------------------------------------------------------------------
  logic [47:0] q[$];
  logic        m_valid = 1'b0;
  logic [47:0] m_data  = '0;
  logic        m_has   = 1'b0;
  logic        m_start = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [23:0] m_hold  = '0;
  logic        m_half  = 1'b0;   // a low-half pixel is waiting for its partner

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_has   = 1'b0;
    m_start = 1'b0;
    m_ovf   = 1'b0;
    m_hold  = '0;
    m_half  = 1'b0;
  endtask

  task automatic model_step();
    logic        acc;
    logic        is_sof;
    logic [23:0] p;
    acc    = cap_en && pix_valid;
    is_sof = acc && pix_sof;
    p      = sw(pix_data);
    m_has   = (q.size() >= BURST_LEN);
    m_start = is_sof;
    m_valid = 1'b0;
    if (is_sof) begin
      q.delete();
      m_ovf  = 1'b0;
      m_hold = p;
      m_half = 1'b1;
    end else begin
      if (fiford && q.size() > 0) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end
      if (acc) begin
        if (m_half) begin
          if (q.size() < DEPTH) q.push_back({p, m_hold});
          else                  m_ovf = 1'b1;
          m_half = 1'b0;
        end else begin
          m_hold = p;
          m_half = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge arstn);
      if (!arstn) model_reset();
      else        model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      check("FIFOVALID",    64'(fifovalid),    64'(m_valid));
      check("FIFODATA",     64'(fifodata),     64'(m_data));
      check("HASDATA",      64'(hasdata),      64'(m_has));
      check("START_SCREEN", 64'(start_screen), 64'(m_start));
      check("OVERFLOW",     64'(overflow),     64'(m_ovf));
      check("WORD_COUNT",   64'(word_count),   64'(q.size()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic cap, input logic vld, input logic sof,
                       input logic [23:0] d, input logic rd);
    cap_en    = cap;
    pix_valid = vld;
    pix_sof   = sof;
    pix_data  = d;
    fiford    = rd;
    @(negedge clk);
  endtask

  task automatic pix(input logic [23:0] d);
    drive(1'b1, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic sof_pix(input logic [23:0] d);
    drive(1'b1, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic rd();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
  endtask

  initial begin
    int rd_thresh;
    #1 arstn = 1'b0;
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    check("reset WORD_COUNT", 64'(word_count), 64'd0);
    check("reset FIFODATA",   64'(fifodata),   64'd0);

    // Basic pairing and read latency.
    sof_pix(24'h112233);
    check("sof START_SCREEN", 64'(start_screen), 64'd1);
    pix(24'h445566);
    check("start pulse width", 64'(start_screen), 64'd0);
    check("first word count",  64'(word_count),   64'd1);
    pix(24'h778899);
    pix(24'hAABBCC);
    check("two words", 64'(word_count), 64'd2);
    rd();
    check("read0 valid", 64'(fifovalid), 64'd1);
    check("read0 data",  64'(fifodata),  64'(W0));
    rd();
    check("read1 data",  64'(fifodata),  64'(W1));
    idle();
    check("valid drop",  64'(fifovalid), 64'd0);
    check("data holds",  64'(fifodata),  64'(W1));

    // HASDATA threshold.
    sof_pix(24'h000001);
    for (int i = 2; i <= 16; i++) pix(24'(i));
    check("8 words",        64'(word_count), 64'd8);
    check("hasdata lag",    64'(hasdata),    64'd0);
    idle();
    check("hasdata rise",   64'(hasdata),    64'd1);
    rd();
    check("7 words",        64'(word_count), 64'd7);
    idle();
    check("hasdata fall",   64'(hasdata),    64'd0);

    // Overflow, then flush by SOF, then full push+pop.
    sof_pix(24'h100000);
    for (int i = 1; i < 128; i++) pix(24'h100000 + 24'(i));
    check("full count",     64'(word_count), 64'd64);
    check("no ovf yet",     64'(overflow),   64'd0);
    pix(24'h1FFFF0);
    pix(24'h1FFFF1);
    check("ovf set",        64'(overflow),   64'd1);
    check("count kept",     64'(word_count), 64'd64);
    rd();
    check("oldest word",    64'(fifodata),   64'({sw(24'h100001), sw(24'h100000)}));
    sof_pix(24'h200000);
    check("sof clears ovf", 64'(overflow),   64'd0);
    check("sof flush",      64'(word_count), 64'd0);
    for (int i = 1; i < 128; i++) pix(24'h200000 + 24'(i));
    pix(24'h300000);
    drive(1'b1, 1'b1, 1'b0, 24'h300001, 1'b1);
    check("full push+pop count", 64'(word_count), 64'd64);
    check("full push+pop ovf",   64'(overflow),   64'd0);

    // Mid-pair SOF realignment and empty read.
    pix(24'h000001);
    pix(24'h000002);
    pix(24'h000003);
    sof_pix(24'h0000FF);
    pix(24'h00FF00);
    check("realign count",  64'(word_count), 64'd1);
    rd();
    check("realign word",   64'(fifodata),   64'(W3));
    rd();
    check("empty read",     64'(fifovalid),  64'd0);

    // Asynchronous reset mid-pair with 10 words stored.
    sof_pix(24'h400000);
    for (int i = 1; i <= 20; i++) pix(24'h400000 + 24'(i));
    idle();
    idle();
    check("pre-reset count", 64'(word_count), 64'd10);
    #2 arstn = 1'b0;
    #1;
    check("async WORD_COUNT", 64'(word_count), 64'd0);
    check("async HASDATA",    64'(hasdata),    64'd0);
    check("async FIFODATA",   64'(fifodata),   64'd0);
    check("async FIFOVALID",  64'(fifovalid),  64'd0);
    @(negedge clk);
    arstn = 1'b1;
    pix(24'hABCDEF);
    pix(24'h123456);
    rd();
    check("post-reset word", 64'(fifodata), 64'({sw(24'h123456), sw(24'hABCDEF)}));

    // Randomized traffic with varying read pressure.
    for (int e = 0; e < 6; e++) begin
      rd_thresh = (e % 3 == 0) ? 10 : ((e % 3 == 1) ? 45 : 80);
      for (int c = 0; c < 500; c++) begin
        drive(1'($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 149) == 0),
              24'($urandom),
              1'($urandom_range(0, 99) < rd_thresh));
      end
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
